// File: rtl/sync_fifo_pkg.sv
// Shared constants for the FIFO read-side stream adapter: default payload width,
// the two supported FIFO read latencies and the output queue depth.
package sync_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    localparam int LAT_FWFT = 0;
    localparam int LAT_STD  = 1;

    localparam int OUT_Q_DEPTH = 2;

    typedef logic [1:0] q_level_t;

    function automatic bit legal_latency(input int lat);
        return (lat == LAT_FWFT) || (lat == LAT_STD);
    endfunction

endpackage

// File: rtl/stream_out_queue.sv
// Two-entry register queue feeding the stream master; slot 0 is always the head,
// so the payload and valid outputs come straight from flops.
module stream_out_queue
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] head_o,
    output q_level_t              level_o
);

    logic [DATA_WIDTH-1:0] slot_reg [OUT_Q_DEPTH];
    q_level_t              count_reg;
    q_level_t              count_next;
    q_level_t              wr_pos;
    logic                  valid_reg;

    // A push that coincides with a pop lands one slot lower, behind the shifted entries.
    assign wr_pos = count_reg - {1'b0, pop_i};

    always_comb begin
        count_next = count_reg;
        case ({push_i, pop_i})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            valid_reg <= (count_next != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < OUT_Q_DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
        end else if (!flush_i) begin
            for (int i = 0; i < OUT_Q_DEPTH - 1; i++) begin
                if (pop_i) begin
                    slot_reg[i] <= slot_reg[i+1];
                end
            end
            for (int i = 0; i < OUT_Q_DEPTH; i++) begin
                if (push_i && (wr_pos == q_level_t'(i))) begin
                    slot_reg[i] <= push_data_i;
                end
            end
        end
    end

    assign valid_o = valid_reg;
    assign head_o  = slot_reg[0];
    assign level_o = count_reg;

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Turns a synchronous FIFO read port into a valid/ready stream master. Reads are
// issued only when the output queue is guaranteed room for every word in flight.
module sync_fifo_stream_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int READ_LATENCY = LAT_STD
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_read_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            level_o
);

    logic       pop;
    logic       push;
    logic       inflight;
    logic [2:0] committed;

    assign pop       = m_valid_o & m_ready_i;
    assign committed = {1'b0, level_o} + {2'b00, inflight};

    // A pop this cycle frees a slot, which keeps full throughput with a full queue.
    assign fifo_read_o = !fifo_empty_i && !flush_i && !rst_i
                         && ((committed < 3'(OUT_Q_DEPTH)) || pop);

    generate
        if (!legal_latency(READ_LATENCY)) begin : g_bad_latency
            $error("sync_fifo_stream_reader: READ_LATENCY must be 0 or 1");
        end

        if (READ_LATENCY == LAT_STD) begin : g_std
            logic inflight_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    inflight_reg <= 1'b0;
                end else begin
                    inflight_reg <= fifo_read_o;
                end
            end

            assign inflight = inflight_reg;
            assign push     = inflight_reg & ~flush_i;
        end else begin : g_fwft
            assign inflight = 1'b0;
            assign push     = fifo_read_o;
        end
    endgenerate

    stream_out_queue #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_data_i (fifo_rd_data_i),
        .pop_i       (pop),
        .valid_o     (m_valid_o),
        .head_o      (m_data_o),
        .level_o     (level_o)
    );

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for the FIFO stream reader: one FWFT and one standard-latency instance share
// stimulus; each is mirrored by an index-based model of its source FIFO and output queue.
module tb_sync_fifo_stream_reader;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          ready;
    logic          fifo_empty [2];
    logic          fifo_read  [2];
    logic [DW-1:0] rd_data    [2];
    logic          m_valid    [2];
    logic [DW-1:0] m_data     [2];
    logic [1:0]    level      [2];

    sync_fifo_stream_reader #(.DATA_WIDTH(DW), .READ_LATENCY(0)) u_dut_fwft (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fifo_empty_i(fifo_empty[0]), .fifo_read_o(fifo_read[0]), .fifo_rd_data_i(rd_data[0]),
        .m_valid_o(m_valid[0]), .m_ready_i(ready), .m_data_o(m_data[0]), .level_o(level[0])
    );

    sync_fifo_stream_reader #(.DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut_std (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fifo_empty_i(fifo_empty[1]), .fifo_read_o(fifo_read[1]), .fifo_rd_data_i(rd_data[1]),
        .m_valid_o(m_valid[1]), .m_ready_i(ready), .m_data_o(m_data[1]), .level_o(level[1])
    );

    // Source FIFO contents are shared; each instance has its own read pointer.
    logic [DW-1:0] src_mem [4096];
    int            wr_ptr;
    int            rd_ptr   [2];
    int            oq_head  [2];
    int            oq_cnt   [2];
    bit            inf      [2];
    int            inf_idx  [2];
    bit            zero_chk [2];

    bit c_rst, c_flush, c_ready, c_mask;

    int n_cmp, n_bad, cyc, phase_cyc;
    logic [7:0]    rd_mask   [2];
    logic [7:0]    v_mask    [2];
    int            dut_rd    [2];
    int            dut_pops  [2];
    logic [DW-1:0] dut_first [2];

    function automatic logic [DW-1:0] src(input int i);
        return src_mem[i & 4095];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic add_word(input logic [DW-1:0] w);
        src_mem[wr_ptr & 4095] = w;
        wr_ptr++;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            rd_mask[k]   = '0;
            v_mask[k]    = '0;
            dut_rd[k]    = 0;
            dut_pops[k]  = 0;
            dut_first[k] = '0;
        end
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model to the next edge.
    task automatic step();
        bit empty_m [2];
        bit exp_valid, pop_m, exp_read, push_m;
        int push_idx;
        @(negedge clk);
        rst   = c_rst;
        flush = c_flush;
        ready = c_ready;
        for (int k = 0; k < 2; k++) begin
            empty_m[k]    = (wr_ptr == rd_ptr[k]) || c_mask;
            fifo_empty[k] = empty_m[k];
        end
        rd_data[0] = empty_m[0] ? $urandom : src(rd_ptr[0]);
        rd_data[1] = inf[1] ? src(inf_idx[1]) : $urandom;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_valid = (oq_cnt[k] != 0);
            pop_m     = exp_valid && c_ready;
            exp_read  = !empty_m[k] && !c_flush && !c_rst
                        && (((oq_cnt[k] + int'(inf[k])) < 2) || pop_m);

            chk($sformatf("lat%0d.level", k), 32'(level[k]), 32'(oq_cnt[k]));
            chk($sformatf("lat%0d.valid", k), 32'(m_valid[k]), 32'(exp_valid));
            if (exp_valid)
                chk($sformatf("lat%0d.data", k), m_data[k], src(oq_head[k]));
            else if (zero_chk[k])
                chk($sformatf("lat%0d.data_zero", k), m_data[k], 32'd0);
            chk($sformatf("lat%0d.fifo_read", k), 32'(fifo_read[k]), 32'(exp_read));
            if (empty_m[k])
                chk($sformatf("lat%0d.read_when_empty", k), 32'(fifo_read[k]), 32'd0);

            if (phase_cyc >= 0 && phase_cyc < 8) begin
                rd_mask[k][phase_cyc] = fifo_read[k];
                v_mask[k][phase_cyc]  = m_valid[k];
            end
            if (fifo_read[k]) dut_rd[k]++;
            if (m_valid[k] && c_ready) begin
                if (dut_pops[k] == 0) dut_first[k] = m_data[k];
                dut_pops[k]++;
                $display("xfer lat%0d cyc=%0d word=%h", k, cyc, m_data[k]);
            end

            if (c_rst || c_flush) begin
                oq_cnt[k] = 0;
                inf[k]    = 1'b0;
                if (c_rst) zero_chk[k] = 1'b1;
            end else begin
                if (pop_m) begin
                    oq_head[k]++;
                    oq_cnt[k]--;
                end
                push_m   = (k == 1) ? inf[1] : exp_read;
                push_idx = (k == 1) ? inf_idx[1] : rd_ptr[0];
                if (push_m) begin
                    if (oq_cnt[k] == 0) oq_head[k] = push_idx;
                    oq_cnt[k]++;
                    zero_chk[k] = 1'b0;
                end
                if (k == 1) begin
                    inf[1]     = exp_read;
                    inf_idx[1] = rd_ptr[1];
                end
                if (exp_read) rd_ptr[k]++;
            end
        end
        phase_cyc++;
        cyc++;
        @(posedge clk);
    endtask

    // Hold reset, empty the source FIFO, load n words, and leave reset released for cycle 1.
    task automatic reset_and_load(input int n, input logic [DW-1:0] base);
        c_rst = 1'b1; c_flush = 1'b0; c_ready = 1'b0; c_mask = 1'b0;
        phase_cyc = 8;
        step();
        step();
        rd_ptr[0] = wr_ptr;
        rd_ptr[1] = wr_ptr;
        for (int i = 0; i < n; i++) add_word(base + DW'(i));
        c_rst = 1'b0;
        clear_stats();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; phase_cyc = 8; wr_ptr = 0;
        for (int k = 0; k < 2; k++) begin
            rd_ptr[k] = 0; oq_head[k] = 0; oq_cnt[k] = 0;
            inf[k] = 1'b0; inf_idx[k] = 0; zero_chk[k] = 1'b1;
            fifo_empty[k] = 1'b1; rd_data[k] = '0;
        end
        clear_stats();
        rst = 1'b1; flush = 1'b0; ready = 1'b0;
        c_rst = 1'b1; c_flush = 1'b0; c_ready = 1'b0; c_mask = 1'b0;
        repeat (2) @(posedge clk);

        // Latency and back-to-back streaming of three words.
        reset_and_load(3, 32'hA1);
        c_ready = 1'b1;
        phase_cyc = 1;
        repeat (7) step();
        phase_cyc = 8;
        chk("p1.read_cycles_fwft", 32'(rd_mask[0]), 32'h0E);
        chk("p1.read_cycles_std",  32'(rd_mask[1]), 32'h0E);
        chk("p1.valid_cycles_fwft", 32'(v_mask[0]), 32'h1C);
        chk("p1.valid_cycles_std",  32'(v_mask[1]), 32'h38);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p1.lat%0d.words", k), 32'(dut_pops[k]), 32'd3);
            chk($sformatf("p1.lat%0d.first", k), dut_first[k], 32'hA1);
        end

        // Back-pressure: only two reads may be outstanding, head held.
        reset_and_load(5, 32'hB0);
        repeat (6) step();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p2.lat%0d.reads_held", k), 32'(dut_rd[k]), 32'd2);
            chk($sformatf("p2.lat%0d.level_held", k), 32'(level[k]), 32'd2);
            chk($sformatf("p2.lat%0d.head_held", k), m_data[k], 32'hB0);
        end
        c_ready = 1'b1;
        repeat (8) step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p2.lat%0d.words", k), 32'(dut_pops[k]), 32'd5);
            chk($sformatf("p2.lat%0d.reads", k), 32'(dut_rd[k]), 32'd5);
        end

        // Flush with one word queued and one in flight on the standard FIFO.
        reset_and_load(4, 32'hC0);
        repeat (2) step();
        c_flush = 1'b1;
        step();
        c_flush = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p3.lat%0d.valid_after_flush", k), 32'(m_valid[k]), 32'd0);
            chk($sformatf("p3.lat%0d.level_after_flush", k), 32'(level[k]), 32'd0);
        end
        c_ready = 1'b1;
        repeat (8) step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p3.lat%0d.words", k), 32'(dut_pops[k]), 32'd2);
            chk($sformatf("p3.lat%0d.first", k), dut_first[k], 32'hC2);
        end

        // Randomised traffic: empty toggling every cycle, then unmasked.
        for (int i = 0; i < 1500; i++) begin
            c_mask  = (i % 2) == 0;
            c_ready = ($urandom % 3) != 0;
            c_flush = ($urandom % 64) == 0;
            if (($urandom % 3) != 0) add_word($urandom);
            step();
        end
        for (int i = 0; i < 500; i++) begin
            c_mask  = 1'b0;
            c_ready = ($urandom % 4) != 0;
            c_flush = ($urandom % 128) == 0;
            if (($urandom % 4) != 0) add_word($urandom);
            step();
        end

        // Reset while the queue is full and a standard-FIFO read is outstanding.
        c_flush = 1'b0; c_mask = 1'b0; c_ready = 1'b0;
        for (int i = 0; i < 6; i++) add_word(32'hD0 + DW'(i));
        repeat (5) step();
        #1;
        chk("p5.level_before_reset", 32'(level[1]), 32'd2);
        c_ready = 1'b1;
        step();
        c_ready = 1'b0;
        c_rst = 1'b1;
        step();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p5.lat%0d.valid_reset", k), 32'(m_valid[k]), 32'd0);
            chk($sformatf("p5.lat%0d.level_reset", k), 32'(level[k]), 32'd0);
            chk($sformatf("p5.lat%0d.data_reset", k), m_data[k], 32'd0);
        end
        step();
        c_rst = 1'b0;
        c_ready = 1'b1;
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_stream_reader.md
Name: sync_fifo_stream_reader

Overview:
- Downstream consumer of the synchronous FIFO buffer's read port.
- Converts the FIFO's read_i/empty_o/rd_data_o protocol into a valid/ready stream master with full throughput and registered outputs.
- Hides the FIFO read latency: 0 cycles in FWFT mode, 1 cycle in standard mode.
- Buffers in-flight words in a 2-entry output queue so downstream back-pressure never loses data.

Parameters:
- DATA_WIDTH, 32, width of FIFO word and stream payload.
- READ_LATENCY, 1, cycles from fifo_read_o to valid fifo_rd_data_i: 0 = FWFT FIFO, 1 = standard FIFO. Any other value is a compile-time error.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous discard of all buffered and in-flight words.
- fifo_empty_i  in  1  FIFO empty status.
- fifo_read_o  out  1  FIFO read request.
- fifo_rd_data_i  in  DATA_WIDTH  FIFO read data.
- m_valid_o  out  1  stream word valid.
- m_ready_i  in  1  downstream accepts.
- m_data_o  out  DATA_WIDTH  stream payload, head of queue.
- level_o  out  2  words held in output queue (0..2).

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at a rising edge): occupancy=0, inflight=0, m_valid_o=0, level_o=0, m_data_o=0. While rst_i=1, fifo_read_o=0.
- pop = m_valid_o & m_ready_i. Queue head leaves on pop. m_data_o and m_valid_o are stable while m_valid_o & !m_ready_i.
- Credit rule: fifo_read_o = !fifo_empty_i & !flush_i & !rst_i & ((occupancy + inflight < 2) | pop).
  - inflight is 1 bit and applies only when READ_LATENCY=1; it is forced to 0 when READ_LATENCY=0.
  - fifo_read_o is never asserted while fifo_empty_i=1.
- READ_LATENCY=1:
  - inflight <= fifo_read_o.
  - A word is pushed at the edge ending the cycle after the read.
  - m_valid_o rises 2 cycles after the first fifo_read_o.
- READ_LATENCY=0: the word is pushed at the same edge as fifo_read_o. m_valid_o rises 1 cycle after fifo_read_o.
- Simultaneous push and pop: occupancy is unchanged and the head advances. With occupancy=1, the pushed word becomes the new head.
- Sustained throughput: 1 word/cycle when the FIFO is non-empty and m_ready_i=1.
- Occupancy never exceeds 2. The credit rule guarantees this. Overflow is a design error; the bench asserts it never occurs.
- Order: words leave in exactly the order read from the FIFO, with no duplication or loss.
- flush_i=1 at an edge:
  - occupancy <= 0, m_valid_o <= 0.
  - A READ_LATENCY=1 word in flight is discarded (inflight cleared, no push).
  - fifo_read_o is 0 during the flush cycle.
  - A pop in the flush cycle still counts as accepted downstream.
- Reset mid-operation behaves as flush and also zeroes m_data_o.
- level_o = occupancy, registered.

Decomposition:
- Package sync_fifo_pkg: DATA_WIDTH default constant, READ_LATENCY legal-value constants (LAT_FWFT=0, LAT_STD=1), queue depth constant OUT_Q_DEPTH=2.
- Sub-module stream_out_queue: 2-entry register queue with push/pop/flush, head output, occupancy.
- The top holds only the credit/inflight logic.

Test Plan:
- Reset, FIFO holding 0xA1,0xA2,0xA3, m_ready_i=1, READ_LATENCY=1 → fifo_read_o in cycles 1,2,3; m_data_o 0xA1/0xA2/0xA3 valid in cycles 3,4,5; no gaps.
- Same data, READ_LATENCY=0 → valid in cycles 2,3,4.
- m_ready_i=0 with 5 words available → exactly 2 reads issued, level_o=2, m_data_o held at the first word. Raise m_ready_i → remaining 3 words stream in order at 1/cycle.
- flush_i on the cycle after a READ_LATENCY=1 read with occupancy=1 → next cycle m_valid_o=0, level_o=0. The in-flight word never appears. Subsequent words resume in order.
- fifo_empty_i toggling every cycle with random m_ready_i → fifo_read_o never high while empty. Scoreboard shows in-order, lossless delivery. Occupancy ≤ 2 always.
- rst_i asserted while level_o=2 and a read is in flight → next cycle all outputs are 0 and no stale word is emitted after release.
